// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory sweep controller: FSM states, command modes and
// the default memory address port width.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DUMP,
    ST_FIN
  } sweep_state_e;

  typedef enum logic {
    MODE_DUMP = 1'b0,
    MODE_FILL = 1'b1
  } sweep_mode_e;

endpackage

// File: rtl/sweep_skid_buf.sv
// Two-entry FIFO holding DUMP beats as {last, data}; the only beat storage in
// the sweep controller. Caller guarantees no push when full, no pop when empty.
module sweep_skid_buf #(
  parameter int unsigned WID = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic [WID-1:0] push_data_i,
  input  logic           push_last_i,
  input  logic           pop_i,
  output logic [WID-1:0] head_data_o,
  output logic           head_last_o,
  output logic [1:0]     count_o
);

  logic [WID-1:0] data_q [2];
  logic [1:0]     last_q;
  logic           rd_q;
  logic           wr_q;
  logic [1:0]     cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) data_q[i] <= '0;
      last_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= push_data_i;
        last_q[wr_q] <= push_last_i;
        wr_q         <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign head_data_o = data_q[rd_q];
  assign head_last_o = last_q[rd_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/mem_sweep_ctrl.sv
// FILL/DUMP sequencer for one registered-read dual-port BRAM.
// MEM_SWEEP_INCR_PATTERN_EN: FILL writes fill_data + addr instead of a constant.
module mem_sweep_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WID_MEM   = 8,
  parameter int unsigned DEPTH_MEM = 2048,
  parameter int unsigned ADDR_W    = MEM_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] fill_data,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic [WID_MEM-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int unsigned   AW        = $clog2(DEPTH_MEM);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH_MEM - 1);

  sweep_state_e     state_q;
  logic [AW-1:0]    addr_q;
  logic [WID_MEM-1:0] fill_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic             issued_all_q;

  logic [1:0]       skid_cnt;
  logic             skid_last;
  logic             pop;
  logic             issue;
  logic [2:0]       credit;
  logic [WID_MEM-1:0] fill_word;

  sweep_skid_buf #(
    .WID (WID_MEM)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (inflight_q),
    .push_data_i (mem_dout),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .head_data_o (out_data),
    .head_last_o (skid_last),
    .count_o     (skid_cnt)
  );

  assign out_valid = (skid_cnt != 2'd0);
  assign out_last  = out_valid && skid_last;
  assign pop       = out_valid && out_ready;

  // Occupancy is counted after this cycle's pop so a streaming consumer
  // sustains one beat per cycle without ever overfilling the buffer.
  always_comb begin
    credit = 3'(skid_cnt) - 3'(pop) + 3'(inflight_q);
    issue  = (state_q == ST_DUMP) && !issued_all_q && (credit < 3'd2);
  end

  always_comb begin
`ifdef MEM_SWEEP_INCR_PATTERN_EN
    fill_word = fill_q + WID_MEM'(addr_q);
`else
    fill_word = fill_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      fill_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      issued_all_q    <= 1'b0;
    end else begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            fill_q       <= fill_data;
            issued_all_q <= 1'b0;
            if (sweep_mode_e'(mode) == MODE_FILL) begin
              state_q <= ST_FILL;
              addr_q  <= '0;
            end else begin
              // raddr already sits at 0 in IDLE, so the start cycle itself
              // issues the read of word 0 and the counter resumes at 1.
              state_q    <= ST_DUMP;
              inflight_q <= 1'b1;
              addr_q     <= AW'(1);
            end
          end
        end
        ST_FILL: begin
          if (addr_q == ADDR_LAST) begin
            state_q <= ST_FIN;
            addr_q  <= '0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_DUMP: begin
          inflight_q      <= issue;
          inflight_last_q <= issue && (addr_q == ADDR_LAST);
          if (issue) begin
            if (addr_q == ADDR_LAST) issued_all_q <= 1'b1;
            else                     addr_q       <= addr_q + 1'b1;
          end
          if (pop && skid_last) begin
            state_q <= ST_FIN;
            addr_q  <= '0;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_FILL) || (state_q == ST_DUMP);
  assign done      = (state_q == ST_FIN);
  assign mem_we    = (state_q == ST_FILL);
  assign mem_waddr = (state_q == ST_FILL) ? ADDR_W'(addr_q) : '0;
  assign mem_raddr = (state_q == ST_DUMP) ? ADDR_W'(addr_q) : '0;
  assign mem_din   = (state_q == ST_FILL) ? fill_word : '0;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Self-checking bench for mem_sweep_ctrl with a behavioural BRAM and an
// expected-contents image; honours MEM_SWEEP_INCR_PATTERN_EN for FILL data.
module tb_mem_sweep_ctrl;

  localparam int WID   = 8;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int AWP   = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WID-1:0]   fill_data = '0;
  logic             busy, done, mem_we, out_valid, out_last;
  logic             out_ready = 1'b0;
  logic [AWP-1:0]   mem_raddr, mem_waddr;
  logic [WID-1:0]   mem_din, mem_dout, out_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WID-1:0] ram     [DEPTH];
  logic [WID-1:0] img     [DEPTH];
  logic [WID-1:0] exp_mem [DEPTH];
  logic           load_en = 1'b0;

  always #5 clk = ~clk;

  mem_sweep_ctrl #(
    .WID_MEM   (WID),
    .DEPTH_MEM (DEPTH),
    .ADDR_W    (AWP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Registered-read dual-port BRAM; load_en models a bitstream (re)init.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= img[i];
    end else if (mem_we) begin
      ram[mem_waddr[AW-1:0]] <= mem_din;
    end
    mem_dout <= ram[mem_raddr[AW-1:0]];
  end

  function automatic logic [WID-1:0] fill_word(input logic [WID-1:0] fd, input int k);
`ifdef MEM_SWEEP_INCR_PATTERN_EN
    return fd + WID'(k);
`else
    return fd;
`endif
  endfunction

  task automatic start_cmd(input logic m, input logic [WID-1:0] fd);
    @(posedge clk); #1;
    start = 1'b1; mode = m; fill_data = fd;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); fill_data = WID'($urandom);
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      img[i]     = WID'($urandom);
      exp_mem[i] = img[i];
    end
    @(posedge clk); #1; load_en = 1'b1;
    @(posedge clk); #1; load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, mem_we, out_valid, out_last} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got busy/done/we/valid/last=%b want 00000",
               {busy, done, mem_we, out_valid, out_last});
    end
    n_cmp++;
    if (mem_raddr !== '0 || mem_waddr !== '0) begin
      n_bad++;
      $display("FAIL reset_addr got raddr=%h waddr=%h want 0", mem_raddr, mem_waddr);
    end
    n_cmp++;
    if (mem_din !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data got din=%h out_data=%h want 0", mem_din, out_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_fill(input logic [WID-1:0] fd);
    int n, writes, done_at;
    logic busy_at_done;
    start_cmd(1'b1, fd);
    n = 1; writes = 0; done_at = -1; busy_at_done = 1'bx;
    while (n < 3000 && done_at < 0) begin
      if (mem_we === 1'b1) begin
        n_cmp++;
        if (mem_waddr !== AWP'(writes) || mem_din !== fill_word(fd, writes) || n != writes + 1) begin
          n_bad++;
          $display("FAIL fill_write k=%0d got waddr=%0d din=%h cycle=%0d want waddr=%0d din=%h cycle=%0d",
                   writes, mem_waddr, mem_din, n, writes, fill_word(fd, writes), writes + 1);
        end
        writes++;
      end
      if (done === 1'b1) begin
        done_at = n;
        busy_at_done = busy;
      end
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (writes != DEPTH) begin
      n_bad++;
      $display("FAIL fill_write_count got %0d want %0d", writes, DEPTH);
    end
    n_cmp++;
    if (done_at != DEPTH + 1) begin
      n_bad++;
      $display("FAIL fill_done_cycle got %0d want %0d", done_at, DEPTH + 1);
    end
    n_cmp++;
    if (busy_at_done !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_busy_at_done got %b want 0", busy_at_done);
    end
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_after_done got done=%b busy=%b we=%b want 0 0 0", done, busy, mem_we);
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = fill_word(fd, i);
  endtask

  task automatic test_dump_full_ready();
    int n, beats, first_v, done_at;
    out_ready = 1'b1;
    start_cmd(1'b0, WID'($urandom));
    n = 1; beats = 0; first_v = -1; done_at = -1;
    while (n < 6000 && done_at < 0) begin
      if (out_valid === 1'b1) begin
        if (first_v < 0) first_v = n;
        n_cmp++;
        if (beats >= DEPTH) begin
          n_bad++;
          $display("FAIL dump_extra_beat got beat %0d want at most %0d beats", beats, DEPTH);
        end else if (out_data !== exp_mem[beats] || out_last !== (beats == DEPTH - 1)
                     || n != first_v + beats) begin
          n_bad++;
          $display("FAIL dump_beat k=%0d got data=%h last=%b cycle=%0d want data=%h last=%b cycle=%0d",
                   beats, out_data, out_last, n, exp_mem[beats], beats == DEPTH - 1, first_v + beats);
        end
        beats++;
      end
      n_cmp++;
      if (mem_we !== 1'b0 || mem_raddr >= AWP'(DEPTH)) begin
        n_bad++;
        $display("FAIL dump_mem_ports got we=%b raddr=%0d want we=0 raddr<%0d", mem_we, mem_raddr, DEPTH);
      end
      if (done === 1'b1) done_at = n;
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (first_v != 2) begin
      n_bad++;
      $display("FAIL dump_first_valid got cycle %0d want 2", first_v);
    end
    n_cmp++;
    if (beats != DEPTH) begin
      n_bad++;
      $display("FAIL dump_beat_count got %0d want %0d", beats, DEPTH);
    end
    n_cmp++;
    if (done_at != DEPTH + 2) begin
      n_bad++;
      $display("FAIL dump_done_cycle got %0d want %0d", done_at, DEPTH + 2);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_dump_backpressure();
    int n, beats, done_at;
    logic hold, r;
    logic [WID-1:0] held_data;
    out_ready = 1'b0;
    start_cmd(1'b0, WID'($urandom));
    n = 1; beats = 0; done_at = -1; hold = 1'b0; held_data = '0;
    while (n < 20000 && done_at < 0) begin
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          n_bad++;
          $display("FAIL stall_stable cycle=%0d got valid=%b data=%h want valid=1 data=%h",
                   n, out_valid, out_data, held_data);
        end
      end
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        n_cmp++;
        if (beats >= DEPTH) begin
          n_bad++;
          $display("FAIL bp_extra_beat got beat %0d want at most %0d beats", beats, DEPTH);
        end else if (out_data !== exp_mem[beats] || out_last !== (beats == DEPTH - 1)) begin
          n_bad++;
          $display("FAIL bp_beat k=%0d got data=%h last=%b want data=%h last=%b",
                   beats, out_data, out_last, exp_mem[beats], beats == DEPTH - 1);
        end
        beats++;
      end
      hold = (out_valid === 1'b1) && !r;
      held_data = out_data;
      if (done === 1'b1) done_at = n;
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (beats != DEPTH || done_at < 0) begin
      n_bad++;
      $display("FAIL bp_completion got beats=%0d done_at=%0d want beats=%0d and done", beats, done_at, DEPTH);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    int n, beats, done_at, writes;
    out_ready = 1'b1;
    start_cmd(1'b0, WID'($urandom));
    n = 1; beats = 0; done_at = -1; writes = 0;
    while (n < 6000 && done_at < 0) begin
      start = (n == 50 || n == 51);
      mode  = 1'b1;
      if (mem_we !== 1'b0) writes++;
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (beats >= DEPTH || out_data !== exp_mem[beats]) begin
          n_bad++;
          $display("FAIL ignored_start_beat k=%0d got data=%h want %h",
                   beats, out_data, (beats < DEPTH) ? exp_mem[beats] : 'x);
        end
        beats++;
      end
      if (done === 1'b1) done_at = n;
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    n_cmp++;
    if (writes != 0) begin
      n_bad++;
      $display("FAIL ignored_start_writes got %0d write cycles want 0", writes);
    end
    n_cmp++;
    if (beats != DEPTH || done_at != DEPTH + 2) begin
      n_bad++;
      $display("FAIL ignored_start_dump got beats=%0d done_at=%0d want %0d %0d",
               beats, done_at, DEPTH, DEPTH + 2);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start_idle got busy=%b want 0", busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int n, beats;
    out_ready = 1'b1;
    start_cmd(1'b0, WID'($urandom));
    n = 1; beats = 0;
    while (n < 3000 && !(out_valid === 1'b1 && beats == 100)) begin
      if (out_valid === 1'b1) beats++;
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (beats != 100) begin
      n_bad++;
      $display("FAIL reset_mid_reach got %0d beats want 100", beats);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, mem_we, done} !== 4'b0 || mem_raddr !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_async got valid/busy/we/done=%b raddr=%0d want 0000 0",
               {out_valid, busy, mem_we, done}, mem_raddr);
    end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_stale cycle=%0d got valid=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got no finish want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef MEM_SWEEP_INCR_PATTERN_EN
    test_fill(8'h10);
`else
    test_fill(8'hA5);
`endif
    test_dump_full_ready();
    preload();
    test_dump_backpressure();
    test_start_ignored();
    test_reset_mid_dump();
    test_dump_full_ready();
    test_fill(WID'($urandom));
    test_dump_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
- Sequencer for one dual-port BRAM instance of WID_MEM x DEPTH_MEM, using the 32-bit raddr/waddr, din/dout, 1-cycle registered-read memory.
- Two commands, both sweeping addresses 0..DEPTH_MEM-1:
  - FILL: write every word.
  - DUMP: read every word and stream it out with valid/ready backpressure.
- Used to preload known contents and to read back contents after bitstream reinit, for comparison against the init file.

Parameters:
- WID_MEM, 8, memory word width in bits.
- DEPTH_MEM, 2048, number of words; must be a power of 2, at least 2.
- ADDR_W, 32, address port width; matches the memory's raddr/waddr.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = DUMP, 1 = FILL; sampled with start.
- fill_data  in  WID_MEM  fill word; sampled with start and held internally.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at command completion.
- mem_raddr  out  ADDR_W  to memory raddr.
- mem_waddr  out  ADDR_W  to memory waddr.
- mem_din  out  WID_MEM  to memory din.
- mem_we  out  1  write enable. The memory instance paired with this block gates its write with mem_we.
- mem_dout  in  WID_MEM  from memory dout; valid 1 cycle after mem_raddr.
- out_data  out  WID_MEM  DUMP stream data.
- out_valid  out  1  DUMP stream valid.
- out_ready  in  1  DUMP stream ready.
- out_last  out  1  high with the beat for address DEPTH_MEM-1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE and the skid buffer is flushed.
  - All outputs are 0, including mem_we, mem_raddr, mem_waddr, out_valid and done.
- FSM states: IDLE, FILL, DUMP, FIN.
  - IDLE: start=1 latches mode and fill_data, clears the address counter, then moves to FILL or DUMP.
  - FILL → FIN after the write to address DEPTH_MEM-1.
  - DUMP → FIN once the last beat has handshaken.
  - FIN: done=1 for one cycle, then IDLE.
- start while busy or in FIN: ignored, with no side effects.
- FILL:
  - mem_we=1, mem_waddr=addr, mem_din=fill_data; one word per cycle with no stalls.
  - DEPTH_MEM write cycles, then FIN. done is asserted DEPTH_MEM+1 cycles after the start cycle.
  - mem_we is 0 in every state other than FILL.
- DUMP:
  - mem_raddr=addr. A read is issued in a cycle only if (skid occupancy + reads in flight) < 2; addr increments per issued read.
  - Returned mem_dout is pushed into the 2-entry skid buffer; out_data/out_valid are the buffer head.
  - A beat transfers when out_valid && out_ready.
  - With out_ready held high: one beat per cycle, first beat out_valid 2 cycles after start.
  - out_valid must not drop and out_data must not change until the handshake completes.
  - No loss or duplication under any out_ready pattern.
- Address counter:
  - $clog2(DEPTH_MEM) bits, zero-extended to ADDR_W.
  - Stops at DEPTH_MEM-1; never wraps within a command.
- out_last: high with the beat for address DEPTH_MEM-1 (tagged in the skid entry).
- Idle outputs: mem_raddr and mem_waddr hold 0 in IDLE and FIN.

Optional Feature:
- Macro: MEM_SWEEP_INCR_PATTERN_EN.
- Defined: FILL writes mem_din = fill_data + addr[WID_MEM-1:0], modulo 2^WID_MEM, so every word is distinct within 2^WID_MEM.
- Undefined: FILL writes constant fill_data.

Decomposition:
- Package mem_ctrl_pkg:
  - sweep_state_e {IDLE, FILL, DUMP, FIN}
  - sweep_mode_e {DUMP=0, FILL=1}
  - localparam MEM_ADDR_W=32
- Sub-module: sweep_skid_buf, a 2-entry FIFO of {last, data} with push/pop/count. It is the only place that stores beats.

Test Plan:
- FILL, fill_data=0xA5, then DUMP with out_ready=1:
  - 2048 beats, all 0xA5.
  - out_last only on beat 2048.
  - done 2049 cycles after the FILL start; back-to-back beats.
- MEM_SWEEP_INCR_PATTERN_EN defined, FILL fill_data=0x10, then DUMP → beat k = (0x10+k) mod 256.
- DUMP with out_ready pseudo-random at 50% duty → exactly 2048 beats, in address order, no repeats; out_data stable while valid && !ready.
- Pulse start with mode=1 during an active DUMP → no writes (mem_we stays 0); DUMP completes unchanged.
- Assert reset (0) at DUMP beat 100 → out_valid, busy, mem_we go to 0 immediately. After release, a new DUMP starts at address 0 with no stale beats.
- FILL, check write timing → mem_we high for exactly 2048 consecutive cycles, mem_waddr 0..2047 in order, busy falls with the done pulse.
